// File: rtl/ppu_quant_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ppu_pkg : shared types and constants for the PPU post-quantization stage.
// Rev 1.0
// ---------------------------------------------------------------------------
package ppu_pkg;

  localparam int PPU_LANES  = 4;
  localparam int PPU_LANE_W = 8;
  localparam int PPU_OFS    = 128;

  typedef enum logic [1:0] {
    PPU_Q_IDLE  = 2'd0,
    PPU_Q_RUN   = 2'd1,
    PPU_Q_DRAIN = 2'd2,
    PPU_Q_DONE  = 2'd3
  } ppu_q_state_e;

  // Strobe for a word whose highest written lane is `lane`.
  function automatic logic [PPU_LANES-1:0] ppu_fill_strb(input logic [1:0] lane);
    logic [PPU_LANES-1:0] strb;
    case (lane)
      2'd0:    strb = 4'b0001;
      2'd1:    strb = 4'b0011;
      2'd2:    strb = 4'b0111;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage : ppu_pkg
`default_nettype wire

// File: rtl/ppu_quant_ctrl_post_quant.sv
`default_nettype none
// ---------------------------------------------------------------------------
// post_quant : psum -> uint8 activation (arithmetic shift, +offset, clamp).
// Rev 1.0
// ---------------------------------------------------------------------------
module post_quant
  import ppu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [5:0]  sf_i,
  output logic [7:0]  q_o
);

  logic signed [31:0] w_shifted;
  logic signed [31:0] w_added;

  // Shift amounts of 32 and above saturate to pure sign fill.
  assign w_shifted = $signed(data_i) >>> sf_i;
  assign w_added   = w_shifted + 32'(PPU_OFS);

  always_comb begin
    q_o = 8'h00;
    if (w_added < 0) begin
      q_o = 8'h00;
    end else if (w_added > 32'sd255) begin
      q_o = 8'hFF;
    end else begin
      q_o = w_added[7:0];
    end
  end

endmodule : post_quant
`default_nettype wire

// File: rtl/ppu_quant_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ppu_quant_ctrl : burst sequencer quantizing psums and packing 4 bytes/word.
// Rev 1.0
// ---------------------------------------------------------------------------
module ppu_quant_ctrl
  import ppu_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [5:0]       scaling_factor_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic             psum_valid_i,
  input  logic [31:0]      psum_data_i,
  output logic             psum_ready_o,
  output logic             ofm_valid_o,
  output logic [31:0]      ofm_data_o,
  output logic [3:0]       ofm_strb_o,
  input  logic             ofm_ready_i
);

  ppu_q_state_e     state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [5:0]       sf_q, sf_d;
  logic [23:0]      pack_q, pack_d;
  logic             ofm_valid_q, ofm_valid_d;
  logic [31:0]      ofm_data_q, ofm_data_d;
  logic [3:0]       ofm_strb_q, ofm_strb_d;

  logic [7:0]       w_q;
  logic [1:0]       w_lane;
  logic             w_accept;
  logic             w_last;
  logic             w_flush;
  logic             w_ofm_hs;
  logic [31:0]      w_word;

  post_quant u_post_quant (
    .data_i (psum_data_i),
    .sf_i   (sf_q),
    .q_o    (w_q)
  );

  assign w_lane       = cnt_q[1:0];
  assign psum_ready_o = (state_q == PPU_Q_RUN) && (!ofm_valid_q || ofm_ready_i);
  assign w_accept     = psum_valid_i && psum_ready_o;
  assign w_last       = (cnt_q == (len_q - LEN_W'(1)));
  assign w_flush      = w_accept && ((w_lane == 2'd3) || w_last);
  assign w_ofm_hs     = ofm_valid_q && ofm_ready_i;

  // Pack register with the incoming byte merged in; upper lanes stay zero.
  always_comb begin
    w_word = {8'h00, pack_q};
    w_word[{w_lane, 3'b000} +: 8] = w_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    sf_d        = sf_q;
    pack_d      = pack_q;
    ofm_valid_d = ofm_valid_q;
    ofm_data_d  = ofm_data_q;
    ofm_strb_d  = ofm_strb_q;

    if (w_ofm_hs) begin
      ofm_valid_d = 1'b0;
      ofm_data_d  = 32'h0;
      ofm_strb_d  = 4'h0;
    end
    // A load in the handshake cycle overrides the clear, so nothing is lost.
    if (w_flush) begin
      ofm_valid_d = 1'b1;
      ofm_data_d  = w_word;
      ofm_strb_d  = ppu_fill_strb(w_lane);
    end

    case (state_q)
      PPU_Q_IDLE: begin
        if (start_i) begin
          len_d   = len_i;
          sf_d    = scaling_factor_i;
          cnt_d   = '0;
          pack_d  = '0;
          state_d = (len_i == '0) ? PPU_Q_DONE : PPU_Q_RUN;
        end
      end
      PPU_Q_RUN: begin
        if (w_accept) begin
          cnt_d  = cnt_q + LEN_W'(1);
          pack_d = w_flush ? 24'h0 : w_word[23:0];
          if (w_last) begin
            state_d = PPU_Q_DRAIN;
          end
        end
      end
      PPU_Q_DRAIN: begin
        if (w_ofm_hs) begin
          state_d = PPU_Q_DONE;
        end
      end
      PPU_Q_DONE: begin
        state_d = PPU_Q_IDLE;
      end
      default: begin
        state_d = PPU_Q_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PPU_Q_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      sf_q        <= 6'd0;
      pack_q      <= 24'h0;
      ofm_valid_q <= 1'b0;
      ofm_data_q  <= 32'h0;
      ofm_strb_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      sf_q        <= sf_d;
      pack_q      <= pack_d;
      ofm_valid_q <= ofm_valid_d;
      ofm_data_q  <= ofm_data_d;
      ofm_strb_q  <= ofm_strb_d;
    end
  end

  assign busy_o      = (state_q != PPU_Q_IDLE);
  assign done_o      = (state_q == PPU_Q_DONE);
  assign ofm_valid_o = ofm_valid_q;
  assign ofm_data_o  = ofm_data_q;
  assign ofm_strb_o  = ofm_strb_q;

endmodule : ppu_quant_ctrl
`default_nettype wire

// File: doc/ppu_quant_ctrl.md
# ppu_quant_ctrl

Sequencer for the PPU post-quantization stage. Accepts a programmed-length burst of signed 32-bit accumulator words (psums) over a valid/ready stream. It quantizes each word to an unsigned 8-bit activation using the existing `post_quant` datapath: arithmetic shift, +128, clamp to 0..255. Four consecutive results are packed little-endian into 32-bit output-feature-map (ofm) words with a byte strobe. The block sits between the accumulator drain path and the ofm write buffer, and reports busy/done to the layer controller.

## Interface
- `LEN_W`, default 16: width of the burst-length field.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `len` input LEN_W: number of psums in the burst; latched on `start`.
- `scaling_factor` input 6: right-shift amount; latched on `start`.
- `busy` output 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done` output 1: one-cycle pulse at the end of the burst.
- `psum_valid` input 1: psum stream valid.
- `psum_data` input 32: psum, two's complement.
- `psum_ready` output 1: psum stream ready.
- `ofm_valid` output 1: packed word valid.
- `ofm_data` output 32: packed word; lane k is bits [8k+7:8k].
- `ofm_strb` output 4: filled lanes of `ofm_data`.
- `ofm_ready` input 1: downstream ready.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE
  - On `start`, latch `len` and `scaling_factor`, and clear the element counter `cnt` and the lane pointer.
  - `len`≠0 → RUN. `len`=0 → DONE.
- RUN
  - `psum_ready` = !`ofm_valid` || `ofm_ready`.
  - Each psum handshake (valid && ready):
    - Quantize with the latched shift.
    - Write the byte into lane `cnt[1:0]` of the pack register.
    - Increment `cnt`.
  - When lane 3 is written, or the element is the last (`cnt`==len−1), load the pack register into the output register:
    - `ofm_valid`=1.
    - `ofm_strb` = filled lanes (0xF, or 0x1/0x3/0x7 for a partial final word).
    - Unfilled lanes are 0x00.
    - Clear the pack register.
  - Last psum accepted → DRAIN.
- DRAIN: wait for the ofm handshake on the final word → DONE.
- DONE: `done`=1 for exactly one cycle → IDLE.
- Output register: `ofm_valid` and `ofm_data` hold stable while `ofm_valid` && !`ofm_ready`. They clear on handshake unless a new word loads in the same cycle.
- Arithmetic follows `post_quant` exactly:
  - shifted = data >>> sf, sign-preserving.
  - added = shifted + 128, 32-bit signed.
  - Clamp <0 → 0 and >255 → 255.
- `start` while not in IDLE is ignored. `len`/`scaling_factor` changes after `start` have no effect on the burst in progress.
- `psum_valid` outside RUN is ignored (`psum_ready`=0).

## Timing
- Reset values: `busy`=0, `done`=0, `psum_ready`=0, `ofm_valid`=0, `ofm_data`=0, `ofm_strb`=0; state IDLE; counters 0.
- Reset mid-burst: next cycle is IDLE with all outputs at their reset values. The partial pack and any pending ofm word are discarded, and no `done` is issued.
- Latency:
  - Psum accept to byte in the pack register: 1 cycle.
  - Fourth/last psum accept to `ofm_valid`: 1 cycle (registered).
- Throughput: one psum per cycle with no backpressure. A full output register blocks `psum_ready` only while `ofm_ready`=0.
- `done` rises 1 cycle after the final ofm handshake. For `len`=0 it rises 1 cycle after `start`.
- `busy` is high in RUN, DRAIN and DONE.
- A psum accept and an ofm handshake may occur in the same cycle; neither is lost.

## Structure
- Package `ppu_pkg`:
  - `ppu_q_state_e` enum (IDLE, RUN, DRAIN, DONE).
  - `PPU_LANES`=4.
  - `PPU_OFS`=128.
- Sub-module: instantiate the existing `post_quant` combinationally on `psum_data` and the latched shift. Do not duplicate its arithmetic.
- Registers: state, `cnt` (LEN_W), pack register (24 bits plus lane fill), output register (data plus strobe).

## Test plan
- len=4, sf=0, psums 0, 127, −128, 200 with no backpressure → one word, `ofm_data`=0xFF00FF80, strb=0xF; `done` 1 cycle after the handshake.
- len=5, sf=4, psums 256, −256, 0, 4096, 16 → word0 0xFF807090 (strb 0xF), then word1 0x00000081 (strb 0x1).
- Same as the first case with `ofm_ready` low for 5 cycles after `ofm_valid` → data/strb stable, `psum_ready` low only while the word is pending, no loss or duplication.
- len=0 `start` → no `ofm_valid`; `busy` high 1 cycle, `done` 1 cycle after `start`.
- `start` and `scaling_factor` toggled mid-burst → ignored; results use the latched sf.
- `rst` asserted after 2 psums of a len=8 burst → next cycle IDLE, all outputs 0, no `done`; a fresh burst then runs correctly.
